// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request/response bundle between the pipeline, the multi-cycle unit and the register file.
// The arbiter uses the slave modport; the requesters and register file side uses master.
interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic [3:0]  a_dest;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [3:0]  b_dest;
  logic [31:0] b_data;
  logic        b_ready;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_data;
  logic        err_pc_write;

  modport master (
    output a_valid, a_dest, a_data, b_valid, b_dest, b_data,
    input  a_ready, b_ready, wb_en, wb_dest, wb_data, err_pc_write
  );

  modport slave (
    input  a_valid, a_dest, a_data, b_valid, b_dest, b_data,
    output a_ready, b_ready, wb_en, wb_dest, wb_data, err_pc_write
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single-port register-file write-back arbiter: pipeline (A) vs buffered multi-cycle unit (B), with starvation guard.
// One registered grant per cycle, latency 1; A stalls via a_ready, B stalls when its 2-entry buffer is full.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int WCNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {PRI_A, FORCE_B} state_e;

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] data;
  } req_t;

  state_e             state_q, state_d;
  logic [1:0]         count_q, count_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  req_t [1:0]         mem_q, mem_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               wb_en_q, wb_en_d;
  logic               err_q, err_d;
  logic [3:0]         wb_dest_q, wb_dest_d;
  logic [31:0]        wb_data_q, wb_data_d;

  logic head_vld, grant_a, grant_b, grant, push;
  req_t head, win;

  assign head_vld    = (count_q != 2'd0);
  assign head        = mem_q[rd_ptr_q];
  assign bus.b_ready = (count_q != 2'(FIFO_DEPTH));
  // Nothing is granted while reset is sampled, so the pipeline never sees an accept that is thrown away.
  assign grant_a     = !rst && bus.a_valid && (state_q == PRI_A || !head_vld);
  assign grant_b     = !rst && head_vld && (state_q == FORCE_B || !bus.a_valid);
  assign grant       = grant_a || grant_b;
  assign push        = bus.b_valid && bus.b_ready;
  assign bus.a_ready = grant_a;

  always_comb begin
    count_d  = count_q + {1'b0, push} - {1'b0, grant_b};
    rd_ptr_d = rd_ptr_q ^ grant_b;
    wr_ptr_d = wr_ptr_q ^ push;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{dest: bus.b_dest, data: bus.b_data};
    end

    // Wait count saturates at the limit; a fresh head starts from zero.
    wcnt_d = wcnt_q;
    if (grant_b || !head_vld) begin
      wcnt_d = '0;
    end else if (grant_a && wcnt_q != WCNT_W'(STARVE_LIMIT)) begin
      wcnt_d = wcnt_q + WCNT_W'(1);
    end

    state_d = state_q;
    if (state_q == PRI_A) begin
      if (wcnt_d == WCNT_W'(STARVE_LIMIT)) state_d = FORCE_B;
    end else begin
      if (grant_b) state_d = PRI_A;
    end

    win = grant_b ? head : '{dest: bus.a_dest, data: bus.a_data};
    wb_en_d   = grant && (win.dest != 4'hF);
    err_d     = grant && (win.dest == 4'hF);
    wb_dest_d = grant ? win.dest : wb_dest_q;
    wb_data_d = grant ? win.data : wb_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PRI_A;
      count_q   <= 2'd0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      mem_q     <= '0;
      wcnt_q    <= '0;
      wb_en_q   <= 1'b0;
      err_q     <= 1'b0;
      wb_dest_q <= 4'd0;
      wb_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      mem_q     <= mem_d;
      wcnt_q    <= wcnt_d;
      wb_en_q   <= wb_en_d;
      err_q     <= err_d;
      wb_dest_q <= wb_dest_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.wb_en        = wb_en_q;
  assign bus.err_pc_write = err_q;
  assign bus.wb_dest      = wb_dest_q;
  assign bus.wb_data      = wb_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario bench for regfile_wb_arbiter: each cycle's expected write-back is queued when stimulus is driven
// and popped when the registered output appears one cycle later.
module tb_regfile_wb_arbiter;

  localparam logic [1:0] K_IDLE = 2'd0, K_WR = 2'd1, K_PC = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  dest;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.STARVE_LIMIT(4), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic drive(input logic av, input logic [3:0] ad, input logic [31:0] adat,
                       input logic bv, input logic [3:0] bd, input logic [31:0] bdat);
    bus.a_valid = av; bus.a_dest = ad; bus.a_data = adat;
    bus.b_valid = bv; bus.b_dest = bd; bus.b_data = bdat;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.wb_en !== 1'b0 || bus.err_pc_write !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: got en=%b err=%b want 0 0", bus.wb_en, bus.err_pc_write);
    end
    n_cmp++;
    if (bus.wb_dest !== 4'd0 || bus.wb_data !== 32'd0) begin
      n_err++; $display("FAIL reset_wb_regs: got dest=%0d data=%h want 0 0", bus.wb_dest, bus.wb_data);
    end
    n_cmp++;
    if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: got b_ready=%b a_ready=%b want 1 0", bus.b_ready, bus.a_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_a_only();
    logic [3:0]  dst [4] = '{4'd3, 4'd0, 4'd14, 4'd9};
    logic [31:0] dat [4] = '{32'hDEADBEEF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hA5A5_5A5A};
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      if (c < 4) drive(1'b1, dst[c], dat[c], 1'b0, 4'd0, 32'd0);
      else       drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      #1;
      n_cmp++;
      if (bus.a_ready !== (c < 4)) begin
        n_err++; $display("FAIL a_only_ready c%0d: got %b want %b", c, bus.a_ready, (c < 4));
      end
      if (c < 4) sb.push_back('{K_WR, dst[c], dat[c]});
      else       sb.push_back('{K_IDLE, 4'd0, 32'd0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (bus.wb_en !== (e.kind == K_WR) || bus.err_pc_write !== (e.kind == K_PC) ||
          (e.kind == K_WR && (bus.wb_dest !== e.dest || bus.wb_data !== e.data))) begin
        n_err++;
        $display("FAIL a_only_wb c%0d: got en=%b err=%b dest=%0d data=%h want kind=%0d dest=%0d data=%h",
                 c, bus.wb_en, bus.err_pc_write, bus.wb_dest, bus.wb_data, e.kind, e.dest, e.data);
      end
    end
  endtask

  // A idle, three B pushes on consecutive cycles: buffer never fills and entries drain in order.
  task automatic test_b_order();
    logic [3:0]  dst [3] = '{4'd1, 4'd2, 4'd6};
    logic [31:0] dat [3] = '{32'h1111_1111, 32'h2222_2222, 32'h6666_6666};
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(1'b0, 4'd0, 32'd0, 1'b1, dst[c], dat[c]);
      else       drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      #1;
      n_cmp++;
      if (bus.b_ready !== 1'b1) begin
        n_err++; $display("FAIL b_order_b_ready c%0d: got %b want 1", c, bus.b_ready);
      end
      if (c >= 1 && c <= 3) sb.push_back('{K_WR, dst[c-1], dat[c-1]});
      else                  sb.push_back('{K_IDLE, 4'd0, 32'd0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (bus.wb_en !== (e.kind == K_WR) || bus.err_pc_write !== (e.kind == K_PC) ||
          (e.kind == K_WR && (bus.wb_dest !== e.dest || bus.wb_data !== e.data))) begin
        n_err++;
        $display("FAIL b_order_wb c%0d: got en=%b err=%b dest=%0d data=%h want kind=%0d dest=%0d data=%h",
                 c, bus.wb_en, bus.err_pc_write, bus.wb_dest, bus.wb_data, e.kind, e.dest, e.data);
      end
    end
  endtask

  task automatic test_starve();
    int   idx = 0;
    logic rdy;
    exp_t e;
    for (int c = 0; c < 9; c++) begin
      drive(c < 8, 4'd10, 32'hA000_0000 + 32'(idx), c == 0, 4'd5, 32'h5555_0005);
      rdy = (c < 8) && (c != 5);
      #1;
      n_cmp++;
      if (bus.a_ready !== rdy) begin
        n_err++; $display("FAIL starve_a_ready c%0d: got %b want %b", c, bus.a_ready, rdy);
      end
      if (c == 5)   sb.push_back('{K_WR, 4'd5, 32'h5555_0005});
      else if (rdy) sb.push_back('{K_WR, 4'd10, 32'hA000_0000 + 32'(idx)});
      else          sb.push_back('{K_IDLE, 4'd0, 32'd0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (bus.wb_en !== (e.kind == K_WR) || bus.err_pc_write !== (e.kind == K_PC) ||
          (e.kind == K_WR && (bus.wb_dest !== e.dest || bus.wb_data !== e.data))) begin
        n_err++;
        $display("FAIL starve_wb c%0d: got en=%b err=%b dest=%0d data=%h want kind=%0d dest=%0d data=%h",
                 c, bus.wb_en, bus.err_pc_write, bus.wb_dest, bus.wb_data, e.kind, e.dest, e.data);
      end
      if (rdy) idx++;
    end
  endtask

  // A valid every cycle while B offers three entries: two fit, both later win via starvation.
  // With do_rst set, reset lands in cycle 5 while the buffer is full and B is being forced.
  task automatic test_b_fill(input logic do_rst);
    int   idx = 0;
    int   last = do_rst ? 11 : 13;
    logic rdy, brdy, a_on;
    exp_t e;
    logic [3:0] bd [3] = '{4'd12, 4'd13, 4'd14};
    for (int c = 0; c < last; c++) begin
      a_on = do_rst ? (c < 6) : (c < 12);
      rst  = do_rst && (c == 5);
      drive(a_on, 4'd7, 32'hC000_0000 + 32'(idx), c < 3, bd[(c < 3) ? c : 0], 32'hB000_0000 + 32'(c));
      rdy  = a_on && !rst && (c != 5) && (c != 10);
      brdy = (c < 2) || (c >= 6);
      #1;
      n_cmp++;
      if (!rst && (bus.a_ready !== rdy || bus.b_ready !== brdy)) begin
        n_err++; $display("FAIL b_fill_ready c%0d rst=%b: got a=%b b=%b want a=%b b=%b",
                          c, do_rst, bus.a_ready, bus.b_ready, rdy, brdy);
      end
      if (!do_rst && c == 5)       sb.push_back('{K_WR, 4'd12, 32'hB000_0000});
      else if (!do_rst && c == 10) sb.push_back('{K_WR, 4'd13, 32'hB000_0001});
      else if (rdy)                sb.push_back('{K_WR, 4'd7, 32'hC000_0000 + 32'(idx)});
      else                         sb.push_back('{K_IDLE, 4'd0, 32'd0});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (bus.wb_en !== (e.kind == K_WR) || bus.err_pc_write !== (e.kind == K_PC) ||
          (e.kind == K_WR && (bus.wb_dest !== e.dest || bus.wb_data !== e.data))) begin
        n_err++;
        $display("FAIL b_fill_wb c%0d rst=%b: got en=%b err=%b dest=%0d data=%h want kind=%0d dest=%0d data=%h",
                 c, do_rst, bus.wb_en, bus.err_pc_write, bus.wb_dest, bus.wb_data, e.kind, e.dest, e.data);
      end
      if (rst) begin
        rst = 1'b0;
        n_cmp++;
        if (bus.b_ready !== 1'b1 || bus.wb_dest !== 4'd0 || bus.wb_data !== 32'd0) begin
          n_err++; $display("FAIL reset_mid_state: got b_ready=%b dest=%0d data=%h want 1 0 0",
                            bus.b_ready, bus.wb_dest, bus.wb_data);
        end
      end
      if (rdy) idx++;
    end
  endtask

  task automatic test_pc_write();
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      case (c)
        0:       drive(1'b1, 4'd15, 32'h0000_0F0F, 1'b0, 4'd0, 32'd0);
        1:       drive(1'b1, 4'd4,  32'h4444_0004, 1'b0, 4'd0, 32'd0);
        2:       drive(1'b0, 4'd0,  32'd0,         1'b1, 4'd15, 32'hBBBB_000F);
        default: drive(1'b0, 4'd0,  32'd0,         1'b0, 4'd0, 32'd0);
      endcase
      #1;
      case (c)
        0:       sb.push_back('{K_PC, 4'd15, 32'h0000_0F0F});
        1:       sb.push_back('{K_WR, 4'd4, 32'h4444_0004});
        3:       sb.push_back('{K_PC, 4'd15, 32'hBBBB_000F});
        default: sb.push_back('{K_IDLE, 4'd0, 32'd0});
      endcase
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if (bus.wb_en !== (e.kind == K_WR) || bus.err_pc_write !== (e.kind == K_PC) ||
          (e.kind == K_WR && (bus.wb_dest !== e.dest || bus.wb_data !== e.data))) begin
        n_err++;
        $display("FAIL pc_write_wb c%0d: got en=%b err=%b dest=%0d data=%h want kind=%0d dest=%0d data=%h",
                 c, bus.wb_en, bus.err_pc_write, bus.wb_dest, bus.wb_data, e.kind, e.dest, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_b_order();
    test_starve();
    test_b_fill(1'b0);
    test_pc_write();
    test_b_fill(1'b1);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the max consecutive cycles a buffered B entry may lose arbitration.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2 (fixed; no other value supported), meaning the B-side buffer entries.
REQ-003 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port a_valid  input  1  pipeline write-back request.
REQ-006 SHALL have port a_dest  input  4  pipeline destination register.
REQ-007 SHALL have port a_data  input  32  pipeline write data.
REQ-008 SHALL have port a_ready  output  1  pipeline request accepted this cycle; pipeline holds a_* while a_valid && !a_ready.
REQ-009 SHALL have port b_valid  input  1  multi-cycle unit (load/multiply) write request.
REQ-010 SHALL have port b_dest  input  4  multi-cycle unit destination register.
REQ-011 SHALL have port b_data  input  32  multi-cycle unit write data.
REQ-012 SHALL have port b_ready  output  1  B buffer can accept; push occurs when b_valid && b_ready.
REQ-013 SHALL have port wb_en  output  1  register file write enable.
REQ-014 SHALL have port wb_dest  output  4  register file write index.
REQ-015 SHALL have port wb_data  output  32  register file write data.
REQ-016 SHALL have port err_pc_write  output  1  one-cycle pulse: a granted request targeted index 15.

Function
REQ-017 SHALL buffer B requests in a 2-entry FIFO (occupancy count 0..2); b_ready = (count != 2), combinational from count only.
REQ-018 SHALL pass A requests unbuffered; A competes only when a_valid is high.
REQ-019 SHALL grant at most one request per cycle: candidates are A (a_valid) and B FIFO head (count != 0).
REQ-020 SHALL operate two states: PRI_A (A wins any conflict) and FORCE_B (FIFO head wins).
REQ-021 SHALL keep a wait counter wcnt, incremented each cycle the FIFO head loses to A, cleared whenever the FIFO head is granted or FIFO is empty.
REQ-022 SHALL transition PRI_A -> FORCE_B when wcnt reaches STARVE_LIMIT; FORCE_B -> PRI_A after exactly one B grant.
REQ-023 SHALL drive a_ready = a_valid && (state == PRI_A || count == 0); a_ready is low whenever a_valid is low.
REQ-024 SHALL register the granted request: wb_en, wb_dest, wb_data valid the cycle after grant (latency 1); wb_en low in cycles with no grant.
REQ-025 SHALL, for a granted request with dest 4'hF, hold wb_en low and pulse err_pc_write high for one cycle (same latency as wb_en).
REQ-026 SHALL, on simultaneous push and pop, keep count unchanged and preserve FIFO order; push when count==2 cannot occur (b_ready low).
REQ-027 SHALL, when a_valid and FIFO empty with b_valid pushing the same cycle, grant A; the pushed entry becomes eligible next cycle.
REQ-028 SHALL retain wb_dest and wb_data values when wb_en is low (no requirement on content).
REQ-029 SHALL perform no data modification; wb_data equals granted data bit-exactly.

Reset
REQ-030 SHALL, while rst is high at a clock edge, set count=0, wcnt=0, state=PRI_A, wb_en=0, err_pc_write=0, wb_dest=0, wb_data=0.
REQ-031 SHALL discard buffered B entries on reset mid-operation; b_ready reads 1 the cycle after reset.
REQ-032 SHALL produce no grant and no write in any cycle where rst is sampled high.

Verification
REQ-033 SHALL cover: A-only: a_valid=1, a_dest=3, a_data=0xDEADBEEF -> a_ready=1 same cycle; next cycle wb_en=1, wb_dest=3, wb_data=0xDEADBEEF.
REQ-034 SHALL cover: B fill: b_valid held 3 cycles, A idle -> b_ready drops only if grants stall; with A continuously valid, b_ready=0 after 2 pushes.
REQ-035 SHALL cover: starvation: A valid every cycle, one B entry (dest 5) -> A granted 4 cycles, 5th cycle a_ready=0 and B granted; wb_dest=5 next cycle; A resumes.
REQ-036 SHALL cover: ordering: push B dest 1 then dest 2, A idle -> wb_dest 1 then 2 on consecutive cycles.
REQ-037 SHALL cover: PC write: a_dest=15 granted -> next cycle wb_en=0, err_pc_write=1 for exactly one cycle.
REQ-038 SHALL cover: reset mid-operation: FIFO count=2, FORCE_B, assert rst one cycle -> wb_en=0, b_ready=1, buffered entries never written.
